// File: rtl/uart_rx_frame_ctrl_if.sv
// Link between the UART rx frame controller and its parity checker and consumer.
// The master side is the frame controller. The slave side is the checker and consumer.
interface uart_rx_frame_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] p_data;
    logic                  sampled_parity_bit;
    logic                  par_chk_en;
    logic                  par_error;
    logic                  data_valid;
    logic                  stop_error;
    logic                  start_glitch;
    logic                  busy;

    modport master (
        output p_data, sampled_parity_bit, par_chk_en,
        output data_valid, stop_error, start_glitch, busy,
        input  par_error
    );

    modport slave (
        input  p_data, sampled_parity_bit, par_chk_en,
        input  data_valid, stop_error, start_glitch, busy,
        output par_error
    );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive front-end: oversampling, 2-of-3 bit vote, frame FSM, parity/stop qualification.
// Optional macro RX_INPUT_SYNC_EN puts a 2-flop synchroniser (reset to 1) in front of rx_in.
module uart_rx_frame_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    uart_rx_frame_ctrl_if.master  rx_if
);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    state_t state, state_nx;

    logic rx;
`ifdef RX_INPUT_SYNC_EN
    logic [1:0] rx_sync;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_sync <= 2'b11;
        else        rx_sync <= {rx_sync[0], rx_in};
    end
    assign rx = rx_sync[1];
`else
    assign rx = rx_in;
`endif

    logic [PRESCALE_W-1:0] p_sel, p_lat, half, edge_cnt;
    logic [BW-1:0]         bit_cnt;
    logic                  s0, s1, vote;
    logic                  at_s0, at_s1, at_vote, at_end;
    logic                  shift_en, par_ld;
    logic                  dv_nx, se_nx, sg_nx, pce_nx;

    // Unsupported prescale values fall back to 8 clocks per bit
    always_comb begin
        case (prescale)
            PRESCALE_W'(8), PRESCALE_W'(16), PRESCALE_W'(32): p_sel = prescale;
            default:                                           p_sel = PRESCALE_W'(8);
        endcase
    end

    assign half    = {1'b0, p_lat[PRESCALE_W-1:1]};
    assign at_s0   = (edge_cnt == half - ONE);
    assign at_s1   = (edge_cnt == half);
    assign at_vote = (edge_cnt == half + ONE);
    assign at_end  = (edge_cnt == p_lat - ONE);
    assign vote    = (s0 & s1) | (s0 & rx) | (s1 & rx);

    always_comb begin
        state_nx = state;
        shift_en = 1'b0;
        par_ld   = 1'b0;
        dv_nx    = 1'b0;
        se_nx    = 1'b0;
        sg_nx    = 1'b0;
        pce_nx   = 1'b0;
        case (state)
            S_IDLE:  if (!rx) state_nx = S_START;
            S_START: begin
                if (at_vote && vote) begin
                    sg_nx    = 1'b1;
                    state_nx = S_IDLE;
                end else if (at_end) begin
                    state_nx = S_DATA;
                end
            end
            S_DATA: begin
                shift_en = at_vote;
                if (at_end && bit_cnt == BW'(DATA_WIDTH))
                    state_nx = par_en ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                par_ld = at_vote;
                pce_nx = at_vote;
                if (at_end) state_nx = S_STOP;
            end
            // Return to IDLE at the vote so the next start edge is caught early
            S_STOP: begin
                if (at_vote) begin
                    state_nx = S_IDLE;
                    if (!vote)                           se_nx = 1'b1;
                    else if (!(par_en && rx_if.par_error)) dv_nx = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                    <= S_IDLE;
            p_lat                    <= PRESCALE_W'(8);
            edge_cnt                 <= '0;
            bit_cnt                  <= '0;
            s0                       <= 1'b0;
            s1                       <= 1'b0;
            rx_if.p_data             <= '0;
            rx_if.sampled_parity_bit <= 1'b0;
            rx_if.par_chk_en         <= 1'b0;
            rx_if.data_valid         <= 1'b0;
            rx_if.stop_error         <= 1'b0;
            rx_if.start_glitch       <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE) p_lat <= p_sel;
            if (state == S_IDLE || state_nx == S_IDLE || at_end) edge_cnt <= '0;
            else                                                 edge_cnt <= edge_cnt + ONE;
            if (state != S_DATA) bit_cnt <= '0;
            else if (at_vote)    bit_cnt <= bit_cnt + BW'(1);
            if (at_s0) s0 <= rx;
            if (at_s1) s1 <= rx;
            if (shift_en) rx_if.p_data <= {vote, rx_if.p_data[DATA_WIDTH-1:1]};
            if (par_ld)   rx_if.sampled_parity_bit <= vote;
            rx_if.par_chk_en   <= pce_nx;
            rx_if.data_valid   <= dv_nx;
            rx_if.stop_error   <= se_nx;
            rx_if.start_glitch <= sg_nx;
        end
    end

    assign rx_if.busy = (state != S_IDLE);
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl with a small even-parity checker model.
module tb_uart_rx_frame_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_in;
    logic [5:0] prescale;
    logic       par_en;

    uart_rx_frame_ctrl_if #(.DATA_WIDTH(8)) u_if ();

    uart_rx_frame_ctrl #(.DATA_WIDTH(8), .PRESCALE_W(6)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_in    (rx_in),
        .prescale (prescale),
        .par_en   (par_en),
        .rx_if    (u_if.master)
    );

    always #5 clk = ~clk;

    // Parity checker model: even parity over data plus parity bit
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)              u_if.par_error <= 1'b0;
        else if (u_if.par_chk_en) u_if.par_error <= ^{u_if.p_data, u_if.sampled_parity_bit};
    end

    int         dv_cnt = 0, se_cnt = 0, sg_cnt = 0, pce_cnt = 0, dbl_cnt = 0;
    logic [7:0] dv_data [8];
    logic       last_spb = 1'b0;
    logic [3:0] prev_stb = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (u_if.data_valid) begin
                dv_data[dv_cnt[2:0]] <= u_if.p_data;
                dv_cnt <= dv_cnt + 1;
            end
            if (u_if.par_chk_en) begin
                last_spb <= u_if.sampled_parity_bit;
                pce_cnt  <= pce_cnt + 1;
            end
            if (u_if.stop_error)   se_cnt <= se_cnt + 1;
            if (u_if.start_glitch) sg_cnt <= sg_cnt + 1;
            if (|(prev_stb & {u_if.data_valid, u_if.stop_error, u_if.start_glitch, u_if.par_chk_en}))
                dbl_cnt <= dbl_cnt + 1;
        end
        prev_stb <= {u_if.data_valid, u_if.stop_error, u_if.start_glitch, u_if.par_chk_en};
    end

    int n_chk = 0, n_fail = 0;
    int b_dv, b_se, b_sg, b_pce;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic has_par, input logic pbit,
                              input logic stopb, input int p);
        hold(1'b0, p);
        for (int i = 0; i < 8; i++) hold(d[i], p);
        if (has_par) hold(pbit, p);
        hold(stopb, p);
    endtask

    task automatic snap();
        #1;
        b_dv = dv_cnt; b_se = se_cnt; b_sg = sg_cnt; b_pce = pce_cnt;
    endtask

    initial begin
        rst_n = 1'b0; rx_in = 1'b1; prescale = 6'd8; par_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pdata", u_if.p_data, 8'h00);
        check("rst_strobes", {u_if.data_valid, u_if.stop_error, u_if.start_glitch, u_if.par_chk_en}, 4'b0);
        check("rst_busy", u_if.busy, 1'b0);
        check("rst_spb", u_if.sampled_parity_bit, 1'b0);
        rst_n = 1'b1;
        hold(1'b1, 5);

        // 1: 0xA5, even parity 0, stop 1
        snap(); prescale = 6'd8; par_en = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 8);
        hold(1'b1, 16); #1;
        check("t1_pce", pce_cnt - b_pce, 1);
        check("t1_spb", last_spb, 1'b0);
        check("t1_dv", dv_cnt - b_dv, 1);
        check("t1_data", dv_data[b_dv[2:0]], 8'hA5);
        check("t1_se", se_cnt - b_se, 0);
        check("t1_busy", u_if.busy, 1'b0);

        // 2: same frame, wrong parity bit
        snap();
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 8);
        hold(1'b1, 16); #1;
        check("t2_pce", pce_cnt - b_pce, 1);
        check("t2_spb", last_spb, 1'b1);
        check("t2_dv", dv_cnt - b_dv, 0);
        check("t2_se", se_cnt - b_se, 0);

        // 3: prescale 16, no parity, stop bit 0
        snap(); prescale = 6'd16; par_en = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 16);
        hold(1'b1, 48); #1;
        check("t3_se", se_cnt - b_se, 1);
        check("t3_dv", dv_cnt - b_dv, 0);
        check("t3_pce", pce_cnt - b_pce, 0);
        check("t3_data", u_if.p_data, 8'h3C);

        // 4: short low pulse rejected as false start
        snap(); prescale = 6'd8;
        hold(1'b0, 3);
        hold(1'b1, 20); #1;
        check("t4_sg", sg_cnt - b_sg, 1);
        check("t4_others", (dv_cnt - b_dv) + (se_cnt - b_se) + (pce_cnt - b_pce), 0);
        check("t4_busy", u_if.busy, 1'b0);

        // 5: prescale 32, back-to-back frames
        snap(); prescale = 6'd32;
        send_frame(8'h01, 1'b0, 1'b0, 1'b1, 32);
        send_frame(8'hFE, 1'b0, 1'b0, 1'b1, 32);
        hold(1'b1, 64); #1;
        check("t5_dv", dv_cnt - b_dv, 2);
        check("t5_data0", dv_data[b_dv[2:0]], 8'h01);
        check("t5_data1", dv_data[3'(b_dv + 1)], 8'hFE);
        check("t5_err", (se_cnt - b_se) + (sg_cnt - b_sg), 0);

        // 6: reset during 4th data bit, then a clean frame
        snap(); prescale = 6'd8;
        hold(1'b0, 8);
        hold(1'b1, 8); hold(1'b0, 8); hold(1'b1, 8);
        hold(1'b0, 4);
        check("t6_busy_pre", u_if.busy, 1'b1);
        rst_n = 1'b0; rx_in = 1'b1;
        @(negedge clk); #1;
        check("t6_rst_pdata", u_if.p_data, 8'h00);
        check("t6_rst_strobes", {u_if.data_valid, u_if.stop_error, u_if.start_glitch, u_if.par_chk_en}, 4'b0);
        check("t6_rst_busy", u_if.busy, 1'b0);
        hold(1'b1, 3);
        rst_n = 1'b1;
        hold(1'b1, 4);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 8);
        hold(1'b1, 16); #1;
        check("t6_dv", dv_cnt - b_dv, 1);
        check("t6_data", dv_data[b_dv[2:0]], 8'h55);
        check("t6_err", (se_cnt - b_se) + (sg_cnt - b_sg), 0);

        check("strobe_width", dbl_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Front-end of the UART receive path, between the raw rx line and the parity checker. It oversamples the line, qualifies the start bit and majority-votes each bit. A frame FSM sequences start, data, parity and stop, assembling the data byte LSB-first. It drives the data, parity bit and check enable into the parity checker, then uses the returned parity error together with the stop-bit check to qualify a one-cycle data_valid.

Parameters:
DATA_WIDTH, 8, data bits per frame (parity checker consumes 8).
PRESCALE_W, 6, width of the prescale input.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_in  in  1  serial line, idle high
prescale  in  PRESCALE_W  clocks per bit; legal 8, 16, 32
par_en  in  1  1 = frame carries a parity bit
par_error  in  1  registered result from the parity checker
p_data  out  DATA_WIDTH  assembled byte, to parity checker and consumer
sampled_parity_bit  out  1  voted parity bit, to parity checker
par_chk_en  out  1  one-cycle strobe to parity checker
data_valid  out  1  one-cycle strobe: p_data good
stop_error  out  1  one-cycle strobe: stop bit sampled low
start_glitch  out  1  one-cycle strobe: false start rejected
busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low. All outputs reset to 0, FSM to IDLE, counters to 0.
- Prescale values other than 8/16/32 behave as 8. prescale is sampled only in IDLE and held for the whole frame.
- edge_cnt runs 0..prescale-1 per bit period and wraps to 0 at the bit boundary. bit_cnt counts data bits.
- Sample points are edge_cnt = P/2-1, P/2 and P/2+1, where P is the latched prescale. The bit value is the 2-of-3 majority, resolved in the cycle edge_cnt = P/2+1.
- IDLE: rx_in = 0 enters START with edge_cnt = 0.
- START:
  - Voted value 1: pulse start_glitch for one cycle and return to IDLE the next cycle.
  - Otherwise, at edge_cnt = P-1 go to DATA.
- DATA:
  - Each voted bit shifts into p_data from the MSB side, so bit 0 is received first. p_data updates the cycle after the vote.
  - After DATA_WIDTH bits, at edge_cnt = P-1, go to PARITY if par_en = 1, else to STOP.
- PARITY: the voted bit is registered into sampled_parity_bit. par_chk_en pulses high for exactly one cycle, the cycle after the vote. At edge_cnt = P-1 go to STOP.
- STOP: at the vote, registered one cycle later:
  - bit = 0: stop_error = 1 and data_valid = 0.
  - bit = 1, par_en = 1 and par_error = 1: data_valid = 0.
  - Otherwise: data_valid = 1.
  - The FSM enters IDLE in the same cycle the strobe is asserted. It does not wait out the rest of the stop bit, so the next frame can resynchronise.
- p_data and sampled_parity_bit hold their values until overwritten by the next frame.
- stop_error and parity failure can both occur in one frame: only stop_error is pulsed, and data_valid stays low.
- rx_in low at the cycle IDLE is re-entered starts a new frame immediately (back-to-back frames).
- Reset asserted mid-frame aborts the frame at once. No strobe is emitted, and all outputs return to 0.
- Strobes are never high for more than one consecutive cycle.

Optional Feature:
RX_INPUT_SYNC_EN: when defined, rx_in passes through a 2-flop synchroniser reset to 1. This adds 2 cycles of latency to every response. When undefined, rx_in is used directly and must be synchronous to clk.

Test Plan:
1. prescale=8, par_en=1, frame 0xA5 with even parity bit 0, stop 1 -> one par_chk_en pulse, sampled_parity_bit=0, data_valid pulse, p_data=0xA5, busy low afterwards.
2. Same frame with parity bit 1 (checker returns par_error=1) -> par_chk_en pulse, no data_valid, no stop_error.
3. prescale=16, par_en=0, frame 0x3C, stop bit 0 -> stop_error pulse, no data_valid, p_data=0x3C.
4. prescale=8, rx_in low for 3 cycles then high -> start_glitch pulse, return to IDLE, no other strobe.
5. prescale=32, par_en=0, frames 0x01 and 0xFE back-to-back with no idle gap -> two data_valid pulses, p_data 0x01 then 0xFE.
6. Reset asserted during the 4th data bit, then frame 0x55 sent -> all outputs 0 during reset, no strobe from the aborted frame, data_valid with p_data=0x55.
